// File: rtl/elastic_buffer_skp_controller_pkg.sv
// Shared elastic-buffer definitions: controller FSM encoding and default tuning constants.
package elastic_buffer_skp_controller_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADD_PEND = 2'd1,
        DEL_PEND = 2'd2,
        HOLD     = 2'd3
    } eb_state_e;

    localparam int DEFAULT_BUFFER_DEPTH = 16;
    localparam int DEFAULT_LOW_WM       = 4;
    localparam int DEFAULT_HIGH_WM      = 12;
    localparam int DEFAULT_HOLDOFF      = 4;
    localparam int DEFAULT_TIMEOUT      = 64;

endpackage

// File: rtl/grayToBin.sv
// Gray-to-binary pointer decode; companion to binToGray on the write side.
module grayToBin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/elastic_buffer_skp_controller.sv
// Read-domain SKP add/delete controller: tracks elastic-buffer fill and requests SKP ordered-set edits.
module elastic_buffer_skp_controller
    import elastic_buffer_skp_controller_pkg::*;
#(
    parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int LOW_WM       = DEFAULT_LOW_WM,
    parameter int HIGH_WM      = DEFAULT_HIGH_WM,
    parameter int HOLDOFF      = DEFAULT_HOLDOFF,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,
    localparam int ADDR_W      = $clog2(BUFFER_DEPTH)
) (
    input  logic              read_clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   gray_write_pointer,
    input  logic [ADDR_W:0]   gray_read_pointer,
    input  logic              buffer_mode,
    input  logic              skp_added,
    input  logic              skp_removed,
    output logic              add_req,
    output logic              del_req,
    output logic [ADDR_W:0]   occupancy,
    output logic              req_timeout,
    output logic              ctrl_busy
);

    localparam int PTR_W   = ADDR_W + 1;
    localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [PTR_W-1:0] bin_write_pointer;
    logic [PTR_W-1:0] bin_read_pointer;
    logic [PTR_W-1:0] occupancy_q;
    logic             occupancy_valid;
    logic [CNT_W-1:0] cycle_cnt;
    eb_state_e        state;
    eb_state_e        state_next;
    logic             pending;
    logic             ack;
    logic             timeout_hit;

    grayToBin #(.W(PTR_W)) u_write_gray_to_bin (
        .gray (gray_write_pointer),
        .bin  (bin_write_pointer)
    );

    grayToBin #(.W(PTR_W)) u_read_gray_to_bin (
        .gray (gray_read_pointer),
        .bin  (bin_read_pointer)
    );

    // Modulo-2^PTR_W subtraction handles pointer wrap, including full and empty.
    // occupancy_valid keeps the FSM from acting on the reset value of occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_q     <= '0;
            occupancy_valid <= 1'b0;
        end else begin
            occupancy_q     <= bin_write_pointer - bin_read_pointer;
            occupancy_valid <= 1'b1;
        end
    end

    assign occupancy = occupancy_q;

    assign pending     = (state == ADD_PEND) || (state == DEL_PEND);
    assign ack         = ((state == ADD_PEND) && skp_added) ||
                         ((state == DEL_PEND) && skp_removed);
    assign timeout_hit = pending && (cycle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // One counter serves both the pending timeout and the hold-off window; it restarts on every state change.
    always_ff @(posedge read_clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (state_next != state || state == IDLE) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (!buffer_mode) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (occupancy_valid && occupancy_q < PTR_W'(LOW_WM)) begin
                        state_next = ADD_PEND;
                    end else if (occupancy_valid && occupancy_q > PTR_W'(HIGH_WM)) begin
                        state_next = DEL_PEND;
                    end
                end
                ADD_PEND: begin
                    if (skp_added || timeout_hit) begin
                        state_next = HOLD;
                    end
                end
                DEL_PEND: begin
                    if (skp_removed || timeout_hit) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (cycle_cnt == CNT_W'(HOLDOFF - 1)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // An acknowledge arriving on the final pending cycle wins over the timeout.
    always_comb begin
        add_req     = (state == ADD_PEND);
        del_req     = (state == DEL_PEND);
        ctrl_busy   = (state != IDLE);
        req_timeout = buffer_mode && timeout_hit && !ack;
    end

endmodule
